// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM controller command port between the LCD
// line-fetch reader (R) and the pixel writer (W). Fixed-length bursts, reader
// priority, and a forced idle gap between bursts for command turnaround.
// Optional feature macro: ARB_FAIRNESS_EN -- writer anti-starvation; after
// MAX_SKIP consecutive lost arbitrations the writer is granted ahead of R.
module sdram_arbiter #(
  parameter int BURST_LEN  = 8,
  parameter int GAP_CYCLES = 1,
  parameter int MAX_SKIP   = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Init_Done,
  input  logic        i_Rd_Req,
  input  logic [21:0] i_Rd_Address,
  output logic        o_Rd_Grant,
  output logic [31:0] o_Rd_Data,
  output logic        o_Rd_Valid,
  output logic        o_Rd_Done,
  input  logic        i_Wr_Req,
  input  logic [21:0] i_Wr_Address,
  input  logic [31:0] i_Wr_Data,
  output logic        o_Wr_Next,
  output logic        o_Wr_Grant,
  output logic        o_Wr_Done,
  output logic [1:0]  o_Command,
  output logic [21:0] o_Data_Address,
  output logic [31:0] o_Data_Write,
  input  logic        i_Data_Write_Done,
  input  logic [31:0] i_Data_Read,
  input  logic        i_Data_Read_Valid
);

  // Controller command encoding shared with the SDRAM controller
  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(BURST_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  if (BURST_LEN < 1 || MAX_SKIP < 0) begin : g_param_check
    $error("sdram_arbiter: BURST_LEN must be >= 1 and MAX_SKIP >= 0");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] word_cnt;
  logic [GW-1:0] gap_cnt;

  logic arb_ok;
  logic grant_rd;
  logic grant_wr;
  logic rd_strobe;
  logic wr_strobe;
  logic burst_strobe;

  // Strobes only count while the matching burst owns the controller
  assign rd_strobe    = (state == S_READ)  && i_Data_Read_Valid;
  assign wr_strobe    = (state == S_WRITE) && i_Data_Write_Done;
  assign burst_strobe = rd_strobe || wr_strobe;
  assign arb_ok       = (state == S_IDLE) && i_Init_Done;

  assign o_Wr_Next    = wr_strobe;
  assign o_Data_Write = (state == S_WRITE) ? i_Wr_Data : '0;

`ifdef ARB_FAIRNESS_EN
  localparam int SW = (MAX_SKIP > 0) ? $clog2(MAX_SKIP + 1) : 1;

  logic [SW-1:0] skip_cnt;
  logic          force_wr;

  // Once the writer has lost MAX_SKIP times in a row it wins the next round
  assign force_wr = (skip_cnt >= SW'(MAX_SKIP));
  assign grant_wr = arb_ok && i_Wr_Req && (!i_Rd_Req || force_wr);
  assign grant_rd = arb_ok && i_Rd_Req && !grant_wr;

  // Count reader wins that left a pending writer waiting
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      skip_cnt <= '0;
    end else if (grant_wr) begin
      skip_cnt <= '0;
    end else if (grant_rd && i_Wr_Req) begin
      skip_cnt <= skip_cnt + SW'(1);
    end
  end
`else
  assign grant_rd = arb_ok && i_Rd_Req;
  assign grant_wr = arb_ok && i_Wr_Req && !i_Rd_Req;
`endif

  // Burst sequencer: arbitration, word/address counting, gap timing
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state          <= S_IDLE;
      o_Command      <= CMD_IDLE;
      o_Data_Address <= '0;
      word_cnt       <= '0;
      gap_cnt        <= '0;
      o_Rd_Grant     <= 1'b0;
      o_Wr_Grant     <= 1'b0;
      o_Rd_Done      <= 1'b0;
      o_Wr_Done      <= 1'b0;
      o_Rd_Valid     <= 1'b0;
      o_Rd_Data      <= '0;
    end else begin
      o_Rd_Done  <= 1'b0;
      o_Wr_Done  <= 1'b0;
      o_Rd_Valid <= rd_strobe;
      if (rd_strobe) begin
        o_Rd_Data <= i_Data_Read;
      end

      case (state)
        S_IDLE: begin
          if (grant_rd) begin
            state          <= S_READ;
            o_Command      <= CMD_READ;
            o_Rd_Grant     <= 1'b1;
            o_Data_Address <= i_Rd_Address;
            word_cnt       <= '0;
          end else if (grant_wr) begin
            state          <= S_WRITE;
            o_Command      <= CMD_WRITE;
            o_Wr_Grant     <= 1'b1;
            o_Data_Address <= i_Wr_Address;
            word_cnt       <= '0;
          end
        end

        S_READ, S_WRITE: begin
          if (burst_strobe) begin
            o_Data_Address <= o_Data_Address + 22'd1;
            word_cnt       <= word_cnt + CW'(1);
            if (word_cnt == LAST_WORD) begin
              o_Command  <= CMD_IDLE;
              o_Rd_Grant <= 1'b0;
              o_Wr_Grant <= 1'b0;
              o_Rd_Done  <= (state == S_READ);
              o_Wr_Done  <= (state == S_WRITE);
              gap_cnt    <= '0;
              state      <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed, table-driven bench for sdram_arbiter with
// hand-written sequences for init gating, priority, address wrap, reset
// abort and grant ordering (ARB_FAIRNESS_EN aware).
module tb_sdram_arbiter;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic        i_Init_Done;
  logic        i_Rd_Req;
  logic [21:0] i_Rd_Address;
  logic        o_Rd_Grant;
  logic [31:0] o_Rd_Data;
  logic        o_Rd_Valid;
  logic        o_Rd_Done;
  logic        i_Wr_Req;
  logic [21:0] i_Wr_Address;
  logic [31:0] i_Wr_Data;
  logic        o_Wr_Next;
  logic        o_Wr_Grant;
  logic        o_Wr_Done;
  logic [1:0]  o_Command;
  logic [21:0] o_Data_Address;
  logic [31:0] o_Data_Write;
  logic        i_Data_Write_Done;
  logic [31:0] i_Data_Read;
  logic        i_Data_Read_Valid;

  int checks = 0;
  int errors = 0;

  sdram_arbiter #(.BURST_LEN(8), .GAP_CYCLES(1), .MAX_SKIP(4)) dut (
    .i_Clk             (i_Clk),
    .i_Rst_n           (i_Rst_n),
    .i_Init_Done       (i_Init_Done),
    .i_Rd_Req          (i_Rd_Req),
    .i_Rd_Address      (i_Rd_Address),
    .o_Rd_Grant        (o_Rd_Grant),
    .o_Rd_Data         (o_Rd_Data),
    .o_Rd_Valid        (o_Rd_Valid),
    .o_Rd_Done         (o_Rd_Done),
    .i_Wr_Req          (i_Wr_Req),
    .i_Wr_Address      (i_Wr_Address),
    .i_Wr_Data         (i_Wr_Data),
    .o_Wr_Next         (o_Wr_Next),
    .o_Wr_Grant        (o_Wr_Grant),
    .o_Wr_Done         (o_Wr_Done),
    .o_Command         (o_Command),
    .o_Data_Address    (o_Data_Address),
    .o_Data_Write      (o_Data_Write),
    .i_Data_Write_Done (i_Data_Write_Done),
    .i_Data_Read       (i_Data_Read),
    .i_Data_Read_Valid (i_Data_Read_Valid)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic        wr_req;
    logic        wr_done_in;
    logic [31:0] wr_data;
    logic [1:0]  exp_cmd;
    logic        exp_grant;
    logic        exp_next;
    logic [21:0] exp_addr;
    logic [31:0] exp_dw;
    logic        exp_done;
  } wvec_t;

  wvec_t wv[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  initial begin
    logic got;
    int   n;
    logic exp_w;

    // Writer burst vectors: word w presented for two cycles, done on the second
    wv[0] = '{1'b1, 1'b0, 32'd1, CMD_IDLE, 1'b0, 1'b0, 22'h000000, 32'd0, 1'b0};
    for (int j = 1; j <= 16; j++) begin
      int w;
      w = (j + 1) / 2;
      wv[j] = '{1'b0, (j % 2 == 0), 32'(w), CMD_WRITE, 1'b1, (j % 2 == 0),
                22'(32'h100 + w - 1), 32'(w), 1'b0};
    end
    wv[17] = '{1'b0, 1'b1, 32'd9, CMD_IDLE, 1'b0, 1'b0, 22'h000108, 32'd0, 1'b1};
    wv[18] = '{1'b0, 1'b0, 32'd9, CMD_IDLE, 1'b0, 1'b0, 22'h000108, 32'd0, 1'b0};
    wv[19] = '{1'b0, 1'b0, 32'd9, CMD_IDLE, 1'b0, 1'b0, 22'h000108, 32'd0, 1'b0};

    i_Rst_n = 1'b0;
    i_Init_Done = 1'b0;
    i_Rd_Req = 1'b0;
    i_Rd_Address = '0;
    i_Wr_Req = 1'b0;
    i_Wr_Address = '0;
    i_Wr_Data = '0;
    i_Data_Write_Done = 1'b0;
    i_Data_Read = '0;
    i_Data_Read_Valid = 1'b0;

    // Reset values
    step();
    step();
    check("rst_cmd", o_Command, CMD_IDLE);
    check("rst_addr", o_Data_Address, 22'h0);
    check("rst_grants", {o_Rd_Grant, o_Wr_Grant}, 2'b00);
    check("rst_strobes", {o_Rd_Valid, o_Rd_Done, o_Wr_Done, o_Wr_Next}, 4'b0000);
    check("rst_rd_data", o_Rd_Data, 32'h0);
    check("rst_data_write", o_Data_Write, 32'h0);
    i_Rst_n = 1'b1;

    // No grant while init is incomplete, even with both requests high
    i_Rd_Req = 1'b1;
    i_Wr_Req = 1'b1;
    i_Rd_Address = 22'h000040;
    i_Wr_Address = 22'h000100;
    for (int c = 0; c < 50; c++) begin
      step();
      check("noinit_cmd", o_Command, CMD_IDLE);
      check("noinit_grants", {o_Rd_Grant, o_Wr_Grant}, 2'b00);
    end
    i_Rd_Req = 1'b0;
    i_Wr_Req = 1'b0;
    i_Init_Done = 1'b1;
    step();

    // Writer-only burst at 0x100, request dropped after grant
    for (int v = 0; v < 20; v++) begin
      i_Wr_Req = wv[v].wr_req;
      i_Data_Write_Done = wv[v].wr_done_in;
      i_Wr_Data = wv[v].wr_data;
      @(negedge i_Clk);
      check($sformatf("wr_cmd[%0d]", v), o_Command, wv[v].exp_cmd);
      check($sformatf("wr_grant[%0d]", v), {o_Rd_Grant, o_Wr_Grant}, {1'b0, wv[v].exp_grant});
      check($sformatf("wr_next[%0d]", v), o_Wr_Next, wv[v].exp_next);
      check($sformatf("wr_addr[%0d]", v), o_Data_Address, wv[v].exp_addr);
      check($sformatf("wr_dw[%0d]", v), o_Data_Write, wv[v].exp_dw);
      check($sformatf("wr_done[%0d]", v), o_Wr_Done, wv[v].exp_done);
      step();
    end
    i_Data_Write_Done = 1'b0;
    i_Wr_Data = '0;

    // Both requests: reader first, wrapping address, 1-cycle valid latency
    i_Rd_Req = 1'b1;
    i_Wr_Req = 1'b1;
    i_Rd_Address = 22'h3FFFFC;
    i_Wr_Address = 22'h000200;
    step();
    check("prio_grants", {o_Rd_Grant, o_Wr_Grant}, 2'b10);
    check("prio_cmd", o_Command, CMD_READ);
    check("rd_start_addr", o_Data_Address, 22'h3FFFFC);
    i_Rd_Req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_Data_Read_Valid = 1'b1;
      i_Data_Read = 32'hA0 + 32'(i);
      i_Data_Write_Done = 1'b1;
      #1;
      check($sformatf("rd_addr[%0d]", i), o_Data_Address, 22'(32'h3FFFFC + i));
      check($sformatf("rd_valid[%0d]", i), o_Rd_Valid, (i > 0));
      if (i > 0) check($sformatf("rd_data[%0d]", i), o_Rd_Data, 32'hA0 + 32'(i - 1));
      check($sformatf("rd_done_early[%0d]", i), o_Rd_Done, 1'b0);
      check($sformatf("rd_wrnext_ignored[%0d]", i), o_Wr_Next, 1'b0);
      check($sformatf("rd_cmd[%0d]", i), o_Command, CMD_READ);
      step();
    end
    i_Data_Read_Valid = 1'b0;
    i_Data_Write_Done = 1'b0;
    check("rd_last_valid", o_Rd_Valid, 1'b1);
    check("rd_last_data", o_Rd_Data, 32'hA7);
    check("rd_done", o_Rd_Done, 1'b1);
    check("rd_end_cmd", o_Command, CMD_IDLE);
    check("rd_end_grant", o_Rd_Grant, 1'b0);
    check("rd_end_addr", o_Data_Address, 22'h000004);
    step();
    check("gap_cmd", o_Command, CMD_IDLE);
    check("gap_no_wgrant", o_Wr_Grant, 1'b0);
    check("gap_done_cleared", {o_Rd_Done, o_Rd_Valid}, 2'b00);
    step();
    check("wr_after_gap_grant", {o_Rd_Grant, o_Wr_Grant}, 2'b01);
    check("wr_after_gap_cmd", o_Command, CMD_WRITE);
    check("wr_after_gap_addr", o_Data_Address, 22'h000200);
    i_Wr_Req = 1'b0;

    // Reset at word 3 of a write aborts it without a done pulse
    for (int k = 0; k < 3; k++) begin
      i_Wr_Data = 32'(k + 1);
      i_Data_Write_Done = 1'b1;
      #1;
      check($sformatf("abort_next[%0d]", k), o_Wr_Next, 1'b1);
      check($sformatf("abort_dw[%0d]", k), o_Data_Write, 32'(k + 1));
      step();
    end
    check("abort_pre_addr", o_Data_Address, 22'h000203);
    i_Wr_Data = 32'd4;
    i_Rst_n = 1'b0;
    #1;
    check("abort_cmd", o_Command, CMD_IDLE);
    check("abort_grants", {o_Rd_Grant, o_Wr_Grant}, 2'b00);
    check("abort_addr", o_Data_Address, 22'h0);
    check("abort_comb", {o_Wr_Next, o_Wr_Done}, 2'b00);
    check("abort_dw", o_Data_Write, 32'h0);
    step();
    i_Rst_n = 1'b1;
    i_Data_Write_Done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("post_rst_cmd", o_Command, CMD_IDLE);
      check("post_rst_done", o_Wr_Done, 1'b0);
    end

    // Grant order with both requests held and strobes every cycle
    i_Rd_Req = 1'b1;
    i_Wr_Req = 1'b1;
    i_Data_Read_Valid = 1'b1;
    i_Data_Write_Done = 1'b1;
    for (int b = 0; b < 10; b++) begin
      got = 1'b0;
      n = 0;
      while (!got && n < 40) begin
        step();
        n++;
        if (o_Rd_Grant || o_Wr_Grant) got = 1'b1;
      end
      check($sformatf("order_grant_seen[%0d]", b), got, 1'b1);
`ifdef ARB_FAIRNESS_EN
      exp_w = (b % 5 == 4);
`else
      exp_w = 1'b0;
`endif
      check($sformatf("order[%0d]", b), {o_Rd_Grant, o_Wr_Grant}, exp_w ? 2'b01 : 2'b10);
      n = 0;
      while ((o_Rd_Grant || o_Wr_Grant) && n < 40) begin
        step();
        n++;
      end
      check($sformatf("order_release[%0d]", b), n, 32'd8);
    end
    i_Rd_Req = 1'b0;
    i_Wr_Req = 1'b0;
    i_Data_Read_Valid = 1'b0;
    i_Data_Write_Done = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller command port between two burst requesters: the LCD line-fetch reader (R) and the pixel writer (W), e.g. the compute engine.
- Sits between the requesters and the SDRAM controller. Drives the controller's command, address and write-data inputs.
- Holds off all traffic until SDRAM initialization completes.
- Fixed-length bursts, reader priority, optional writer anti-starvation.

Parameters:
BURST_LEN, 8, words per burst for both ports (same as READ_BURST_LENGTH)
GAP_CYCLES, 1, idle cycles forced between bursts (command turnaround)
MAX_SKIP, 4, consecutive lost arbitrations before the writer is forced a grant (only with ARB_FAIRNESS_EN)

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Init_Done  in  1  SDRAM init complete; no grants while low
i_Rd_Req  in  1  reader burst request, level
i_Rd_Address  in  22  reader burst start word address
o_Rd_Grant  out  1  reader owns the controller
o_Rd_Data  out  32  read word
o_Rd_Valid  out  1  o_Rd_Data valid strobe
o_Rd_Done  out  1  1-cycle pulse, reader burst finished
i_Wr_Req  in  1  writer burst request, level
i_Wr_Address  in  22  writer burst start word address
i_Wr_Data  in  32  writer head word (first-word-fall-through)
o_Wr_Next  out  1  pop strobe: head word accepted
o_Wr_Grant  out  1  writer owns the controller
o_Wr_Done  out  1  1-cycle pulse, writer burst finished
o_Command  out  2  CMD_IDLE / CMD_WRITE / CMD_READ (sdram.vh constants)
o_Data_Address  out  22  controller word address
o_Data_Write  out  32  controller write data
i_Data_Write_Done  in  1  controller accepted one write word
i_Data_Read  in  32  controller read word
i_Data_Read_Valid  in  1  controller read word valid

Behaviour:
- Reset values: o_Command=CMD_IDLE; all addresses/data 0; all grants, strobes and done pulses 0; state IDLE; counters 0. Reset asserted mid-burst aborts the burst immediately, with no done pulse.
- States: IDLE, READ, WRITE, GAP.
- IDLE, arbitration, evaluated only when i_Init_Done=1:
  - i_Rd_Req wins over i_Wr_Req.
  - On grant: the next edge sets the grant output, loads o_Data_Address from the requester address, clears the word counter, and sets o_Command to CMD_READ or CMD_WRITE.
  - Requests are sampled only in IDLE. A request dropped mid-burst does not shorten the burst.
- READ:
  - Each i_Data_Read_Valid increments o_Data_Address and the word counter.
  - o_Rd_Data and o_Rd_Valid are registered copies of i_Data_Read and i_Data_Read_Valid (1-cycle latency).
  - i_Data_Write_Done is ignored.
- WRITE:
  - o_Data_Write = i_Wr_Data combinationally; it is 0 outside WRITE.
  - o_Wr_Next = i_Data_Write_Done, combinational. The writer presents its next word on the following cycle.
  - Each done increments o_Data_Address and the word counter.
  - i_Data_Read_Valid is ignored.
- Last word (counter = BURST_LEN-1 and the strobe arrives):
  - On that edge: o_Command -> CMD_IDLE, grant drops, Done pulses for 1 cycle, state -> GAP.
  - For a read, o_Rd_Done coincides with the final o_Rd_Valid.
- GAP: hold CMD_IDLE for GAP_CYCLES cycles, then -> IDLE. A requester may hold its Req high throughout.
- Address arithmetic: 22-bit, wraps 0x3FFFFF -> 0.
- Strobes in IDLE or GAP are dropped.
- i_Init_Done falling mid-burst has no effect; the check applies only in IDLE.

Optional Feature:
ARB_FAIRNESS_EN
- Defined: a skip counter increments whenever the reader wins while i_Wr_Req=1. It clears on any writer grant. At MAX_SKIP, the next arbitration with i_Wr_Req=1 grants the writer even if i_Rd_Req=1.
- Undefined: strict reader priority; the skip counter is not built.

Test Plan:
- i_Init_Done=0 with both Req high for 50 cycles -> no grant, o_Command=CMD_IDLE throughout.
- Writer only, address 0x000100, data words 1..8, done every 2nd cycle -> 8 o_Wr_Next pulses; o_Data_Address steps 0x100..0x107 and holds 0x108 after the burst; o_Wr_Done pulses once; CMD_IDLE for 1 cycle; o_Data_Write tracks i_Wr_Data.
- Both Req high at once -> reader is granted first. The writer is granted in the first IDLE after GAP, provided i_Rd_Req is low.
- Reader at 0x3FFFFC -> addresses 0x3FFFFC..0x3FFFFF, then 0x000000..0x000003. o_Rd_Valid trails i_Data_Read_Valid by 1 cycle; o_Rd_Done coincides with the 8th valid.
- i_Rst_n low at word 3 of a write -> outputs are reset immediately; after release, o_Command stays CMD_IDLE until the next Req.
- ARB_FAIRNESS_EN, MAX_SKIP=4, both Req held high -> grant order R,R,R,R,W,R,R,R,R,W. Without the macro: R only.
